// File: rtl/pipe_pkg.sv
// Shared pipeline bundle types for the 5-stage core.
// Stage registers size themselves from these structs.
package pipe_pkg;

  typedef struct packed {
    logic [1:0] result_src;
    logic       mem_write;
    logic       alu_src;
    logic       reg_write;
    logic       jump;
    logic       branch;
    logic [2:0] alu_control;
  } id_ex_ctrl_t;

  typedef struct packed {
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] pc;
    logic [31:0] imm_ext;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
  } id_ex_data_t;

  typedef struct packed {
    logic [1:0] result_src;
    logic       mem_write;
    logic       reg_write;
  } ex_mem_ctrl_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] write_data;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
  } ex_mem_data_t;

  typedef struct packed {
    logic [1:0] result_src;
    logic       reg_write;
  } mem_wb_ctrl_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] read_data;
    logic [31:0] pc_plus4;
    logic [4:0]  rd;
  } mem_wb_data_t;

  localparam int ID_EX_CTRL_W = $bits(id_ex_ctrl_t);
  localparam int ID_EX_DATA_W = $bits(id_ex_data_t);
  localparam int CNT_W_DEF    = 16;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_HALF  = 2'b01,
    ST_FULL  = 2'b11
  } stage_st_t;

endpackage

// File: rtl/pipe_sat_counter.sv
// Saturating event counter, cleared only by reset.
// Holds at all-ones instead of wrapping.
module pipe_sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  localparam logic [W-1:0] ONE = 1;

  // count up on inc until the top value
  always_ff @(posedge clk) begin
    if (reset)
      count <= '0;
    else if (inc && !(&count))
      count <= count + ONE;
  end

endmodule

// File: rtl/pipe_stage_elastic.sv
// Flushable elastic stage register with 2-entry skid.
// State is the pair of entry valid bits.
module pipe_stage_elastic
  import pipe_pkg::*;
#(
  parameter int CTRL_W = ID_EX_CTRL_W,
  parameter int DATA_W = ID_EX_DATA_W,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              main_v, skid_v;
  logic [CTRL_W-1:0] main_c, skid_c;
  logic [DATA_W-1:0] main_d, skid_d;

  stage_st_t st, nxt;
  logic      acc, rel;
  logic      ld_main, ld_skid, mv_skid;

  assign st  = stage_st_t'({skid_v, main_v});
  assign acc = in_valid & in_ready & ~flush;
  assign rel = main_v & out_ready;

  // next state and which entry loads from where
  always_comb begin
    nxt     = st;
    ld_main = 1'b0;
    ld_skid = 1'b0;
    mv_skid = 1'b0;
    unique case (st)
      ST_EMPTY: begin
        if (acc) begin
          nxt     = ST_HALF;
          ld_main = 1'b1;
        end
      end
      ST_HALF: begin
        if (acc && rel) begin
          ld_main = 1'b1;
        end else if (acc) begin
          nxt     = ST_FULL;
          ld_skid = 1'b1;
        end else if (rel) begin
          nxt     = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (rel) begin
          nxt     = ST_HALF;
          mv_skid = 1'b1;
        end
      end
      default: nxt = ST_EMPTY;
    endcase
    if (flush) begin
      nxt     = ST_EMPTY;
      ld_main = 1'b0;
      ld_skid = 1'b0;
      mv_skid = 1'b0;
    end
  end

  // valid bits and control; ctrl kept zero while invalid
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      main_v <= 1'b0;
      skid_v <= 1'b0;
      main_c <= '0;
      skid_c <= '0;
    end else begin
      {skid_v, main_v} <= nxt;
      if (ld_main)
        main_c <= in_ctrl;
      else if (mv_skid)
        main_c <= skid_c;
      else if (nxt == ST_EMPTY)
        main_c <= '0;
      if (ld_skid)
        skid_c <= in_ctrl;
      else if (mv_skid)
        skid_c <= '0;
    end
  end

  // payload moves with its entry and is never cleared by flush
  always_ff @(posedge clk) begin
    if (reset) begin
      main_d <= '0;
      skid_d <= '0;
    end else begin
      if (ld_main)
        main_d <= in_data;
      else if (mv_skid)
        main_d <= skid_d;
      if (ld_skid)
        skid_d <= in_data;
    end
  end

  // upstream ready depends only on state, never on out_ready
  always_comb begin
    in_ready  = ~skid_v & ~reset;
    out_valid = main_v;
    out_ctrl  = main_c;
    out_data  = main_d;
  end

  pipe_sat_counter #(.W(CNT_W)) u_stall (
    .clk   (clk),
    .reset (reset),
    .inc   (main_v & ~out_ready),
    .count (stall_cnt)
  );

  pipe_sat_counter #(.W(CNT_W)) u_bubble (
    .clk   (clk),
    .reset (reset),
    .inc   (~main_v & out_ready),
    .count (bubble_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed bench for pipe_stage_elastic.
// A CNT_W=4 copy shares the inputs for saturation.
module tb_pipe_stage_elastic;
  import pipe_pkg::*;

  localparam int CW = ID_EX_CTRL_W;
  localparam int DW = ID_EX_DATA_W;
  localparam int NW = CNT_W_DEF;

  logic          clk = 1'b0;
  logic          reset, flush, in_valid, out_ready;
  logic          in_ready, out_valid;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [DW-1:0] in_data, out_data;
  logic [NW-1:0] stall_cnt, bubble_cnt;

  logic          in_ready4, out_valid4;
  logic [CW-1:0] out_ctrl4;
  logic [DW-1:0] out_data4;
  logic [3:0]    stall_cnt4, bubble_cnt4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_stage_elastic dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data),
    .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
  );

  pipe_stage_elastic #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready4),
    .in_ctrl(in_ctrl), .in_data(in_data),
    .out_valid(out_valid4), .out_ready(out_ready),
    .out_ctrl(out_ctrl4), .out_data(out_data4),
    .stall_cnt(stall_cnt4), .bubble_cnt(bubble_cnt4)
  );

  task automatic chk(input string tag,
                     input logic [255:0] obs,
                     input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put(input logic v, input int c, input int d);
    in_valid = v;
    in_ctrl  = CW'(c);
    in_data  = DW'(d);
  endtask

  initial begin
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    put(1'b0, 0, 0);
    step(2);
    chk("rst_ovalid", 256'(out_valid), 256'(0));
    chk("rst_octrl", 256'(out_ctrl), 256'(0));
    chk("rst_stall", 256'(stall_cnt), 256'(0));
    chk("rst_bubble", 256'(bubble_cnt), 256'(0));
    chk("rst_iready_hi", 256'(in_ready), 256'(0));
    reset = 1'b0;
    #1;
    chk("rst_iready", 256'(in_ready), 256'(1));

    // idle: 5 bubble cycles
    out_ready = 1'b1;
    step(5);
    chk("idle_bubble", 256'(bubble_cnt), 256'(5));
    chk("idle_stall", 256'(stall_cnt), 256'(0));

    // reset mid-operation from FULL
    reset = 1'b1; step(); reset = 1'b0;
    out_ready = 1'b0;
    put(1'b1, 'h3FF, 'hA);
    step();
    put(1'b1, 'h3FF, 'hB);
    step();
    chk("full_iready", 256'(in_ready), 256'(0));
    chk("full_octrl", 256'(out_ctrl), 256'(10'h3FF));
    chk("full_stall", 256'(stall_cnt), 256'(1));
    put(1'b0, 0, 0);
    reset = 1'b1;
    step();
    chk("mrst_ovalid", 256'(out_valid), 256'(0));
    chk("mrst_octrl", 256'(out_ctrl), 256'(0));
    chk("mrst_stall", 256'(stall_cnt), 256'(0));
    reset = 1'b0;
    #1;
    chk("mrst_iready", 256'(in_ready), 256'(1));

    // streaming 1..8 at full rate
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      put(1'b1, i, i);
      #1;
      chk($sformatf("strm_iready%0d", i), 256'(in_ready), 256'(1));
      step();
      chk($sformatf("strm_ovalid%0d", i), 256'(out_valid), 256'(1));
      chk($sformatf("strm_data%0d", i), 256'(out_data), 256'(i));
      chk($sformatf("strm_ctrl%0d", i), 256'(out_ctrl), 256'(i));
    end
    put(1'b0, 0, 0);
    step();
    chk("strm_drain_v", 256'(out_valid), 256'(0));
    chk("strm_drain_c", 256'(out_ctrl), 256'(0));
    chk("strm_stall", 256'(stall_cnt), 256'(0));

    // backpressure: A then B, hold 3 cycles
    reset = 1'b1; step(); reset = 1'b0;
    out_ready = 1'b0;
    put(1'b1, 'h11, 'hAA);
    step();
    chk("bp_half_data", 256'(out_data), 256'('hAA));
    chk("bp_half_iready", 256'(in_ready), 256'(1));
    put(1'b1, 'h22, 'hBB);
    step();
    chk("bp_full_iready", 256'(in_ready), 256'(0));
    put(1'b0, 0, 0);
    step(3);
    chk("bp_hold_data", 256'(out_data), 256'('hAA));
    chk("bp_hold_ctrl", 256'(out_ctrl), 256'('h11));
    chk("bp_stall", 256'(stall_cnt), 256'(4));
    out_ready = 1'b1;
    step();
    chk("bp_b_valid", 256'(out_valid), 256'(1));
    chk("bp_b_data", 256'(out_data), 256'('hBB));
    chk("bp_b_ctrl", 256'(out_ctrl), 256'('h22));
    chk("bp_b_iready", 256'(in_ready), 256'(1));
    step();
    chk("bp_empty", 256'(out_valid), 256'(0));
    chk("bp_stall_end", 256'(stall_cnt), 256'(4));

    // flush in FULL with C presented
    out_ready = 1'b0;
    put(1'b1, 'h155, 'hD);
    step();
    put(1'b1, 'h2AA, 'hE);
    step();
    chk("fl_full_iready", 256'(in_ready), 256'(0));
    put(1'b1, 'h0F0, 'hC);
    flush = 1'b1;
    step();
    flush = 1'b0;
    put(1'b0, 0, 0);
    chk("fl_full_ovalid", 256'(out_valid), 256'(0));
    chk("fl_full_octrl", 256'(out_ctrl), 256'(0));
    chk("fl_full_iready", 256'(in_ready), 256'(1));
    out_ready = 1'b1;
    step(2);
    chk("fl_full_noC", 256'(out_valid), 256'(0));

    // flush in HALF while C is acceptable: C dropped
    out_ready = 1'b0;
    put(1'b1, 'h3C, 'hF);
    step();
    chk("fl_half_data", 256'(out_data), 256'('hF));
    put(1'b1, 'h0F0, 'hC);
    flush = 1'b1;
    step();
    flush = 1'b0;
    put(1'b0, 0, 0);
    chk("fl_half_ovalid", 256'(out_valid), 256'(0));
    chk("fl_half_octrl", 256'(out_ctrl), 256'(0));
    step();
    chk("fl_half_noC", 256'(out_valid), 256'(0));

    // saturation on the 4-bit copy
    reset = 1'b1; step(); reset = 1'b0;
    out_ready = 1'b0;
    put(1'b1, 'h1, 'h5);
    step();
    put(1'b0, 0, 0);
    step(15);
    chk("sat_at15", 256'(stall_cnt4), 256'(15));
    step(5);
    chk("sat_hold", 256'(stall_cnt4), 256'(15));
    chk("sat_wide", 256'(stall_cnt), 256'(20));
    chk("sat_ovalid4", 256'(out_valid4), 256'(1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
